// File: rtl/note_player.sv
// note_player: plays queued (note index, duration) requests as a square wave
// on a single audio pin.
//
// Requests arrive on a valid/ready handshake and land in a one-entry pending
// slot. The FSM moves the pending entry into the current slot and plays it
// for note_duration milliseconds. A finishing note hands over to a waiting
// request on the same edge, so back-to-back notes play without a gap.
// Index all-ones or >= NOTE_COUNT is a rest: silent for its duration.
//
// Optional feature macro: NOTE_PLAYER_GAP_EN
//   defined   : every request is followed by GAP_MS ms of silence before
//               note_done.
//   undefined : note_done fires at duration expiry.
//
// Parameters:
//   CLOCK_HZ       system clock frequency in Hz
//   NOTE_COUNT     playable notes (1..36), index 0 = C4, semitone steps
//   INDEX_WIDTH    width of note_index
//   DURATION_WIDTH width of note_duration (ms)
//   GAP_MS         articulation gap in ms (macro builds only)
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   note_valid     request present
//   note_ready     pending slot free (registered)
//   note_index     note to play, or rest code
//   note_duration  length in ms
//   audio_output   square wave, 0 when silent (registered)
//   busy           activity or pending request (registered)
//   note_done      one-cycle pulse as each request finishes (registered)

module note_player #(
  parameter int unsigned CLOCK_HZ       = 100000000,
  parameter int unsigned NOTE_COUNT     = 36,
  parameter int unsigned INDEX_WIDTH    = 6,
  parameter int unsigned DURATION_WIDTH = 16,
  parameter int unsigned GAP_MS         = 10
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      note_valid,
  output logic                      note_ready,
  input  logic [INDEX_WIDTH-1:0]    note_index,
  input  logic [DURATION_WIDTH-1:0] note_duration,
  output logic                      audio_output,
  output logic                      busy,
  output logic                      note_done
);

  // Clock cycles per millisecond.
  localparam logic [31:0] TICK = 32'(CLOCK_HZ / 32'd1000);

`ifdef NOTE_PLAYER_GAP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1} state_t;
`endif

  // Half-period in clocks for a given tone frequency; only ever called with
  // constant arguments so the division folds away at elaboration.
  function automatic logic [31:0] hp(input logic [31:0] freq);
    hp = 32'(CLOCK_HZ / (32'd2 * freq));
  endfunction

  // Half-period lookup for the equal-tempered table starting at C4.
  function automatic logic [31:0] half_period(input logic [31:0] idx);
    case (idx)
      32'd0:  half_period = hp(32'd262);
      32'd1:  half_period = hp(32'd277);
      32'd2:  half_period = hp(32'd294);
      32'd3:  half_period = hp(32'd311);
      32'd4:  half_period = hp(32'd330);
      32'd5:  half_period = hp(32'd349);
      32'd6:  half_period = hp(32'd370);
      32'd7:  half_period = hp(32'd392);
      32'd8:  half_period = hp(32'd415);
      32'd9:  half_period = hp(32'd440);
      32'd10: half_period = hp(32'd466);
      32'd11: half_period = hp(32'd494);
      32'd12: half_period = hp(32'd523);
      32'd13: half_period = hp(32'd554);
      32'd14: half_period = hp(32'd587);
      32'd15: half_period = hp(32'd622);
      32'd16: half_period = hp(32'd659);
      32'd17: half_period = hp(32'd698);
      32'd18: half_period = hp(32'd740);
      32'd19: half_period = hp(32'd784);
      32'd20: half_period = hp(32'd831);
      32'd21: half_period = hp(32'd880);
      32'd22: half_period = hp(32'd932);
      32'd23: half_period = hp(32'd988);
      32'd24: half_period = hp(32'd1046);
      32'd25: half_period = hp(32'd1109);
      32'd26: half_period = hp(32'd1175);
      32'd27: half_period = hp(32'd1245);
      32'd28: half_period = hp(32'd1318);
      32'd29: half_period = hp(32'd1397);
      32'd30: half_period = hp(32'd1480);
      32'd31: half_period = hp(32'd1568);
      32'd32: half_period = hp(32'd1661);
      32'd33: half_period = hp(32'd1760);
      32'd34: half_period = hp(32'd1865);
      32'd35: half_period = hp(32'd1976);
      default: half_period = 32'd0;
    endcase
  endfunction

  // Rest code: all-ones, or any index beyond the configured note count.
  function automatic logic is_rest(input logic [INDEX_WIDTH-1:0] idx);
    is_rest = (&idx) || (32'(idx) >= 32'(NOTE_COUNT));
  endfunction

  state_t                    state_r;
  state_t                    state_next_s;
  logic                      pend_valid_r;
  logic [INDEX_WIDTH-1:0]    pend_index_r;
  logic [DURATION_WIDTH-1:0] pend_dur_r;
  logic                      cur_rest_r;
  logic [31:0]               cur_half_r;
  logic [31:0]               tone_cnt_r;
  logic [31:0]               ms_cnt_r;
  logic [31:0]               ms_left_r;
  logic                      audio_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      hs_s;
  logic                      expire_s;
  logic                      load_s;
  logic                      finish_s;

  assign hs_s = note_valid && !pend_valid_r;

  // The timed interval ends on the last cycle of its final millisecond; a
  // zero-length interval ends on its first cycle.
  assign expire_s = (ms_left_r == 32'd0) ||
                    ((ms_left_r == 32'd1) && (ms_cnt_r == (TICK - 32'd1)));

  assign note_ready   = !pend_valid_r;
  assign audio_output = audio_r;
  assign busy         = busy_r;
  assign note_done    = done_r;

  // Next-state logic; load_s moves pending into current, finish_s retires a request.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (pend_valid_r) begin
          load_s       = 1'b1;
          state_next_s = S_PLAY;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_PLAY: begin
        if (expire_s) begin
`ifdef NOTE_PLAYER_GAP_EN
          state_next_s = S_GAP;
`else
          finish_s = 1'b1;
          if (pend_valid_r) begin
            load_s       = 1'b1;
            state_next_s = S_PLAY;
          end else begin
            state_next_s = S_IDLE;
          end
`endif
        end else begin
          state_next_s = S_PLAY;
        end
      end
`ifdef NOTE_PLAYER_GAP_EN
      S_GAP: begin
        if (expire_s) begin
          finish_s = 1'b1;
          if (pend_valid_r) begin
            load_s       = 1'b1;
            state_next_s = S_PLAY;
          end else begin
            state_next_s = S_IDLE;
          end
        end else begin
          state_next_s = S_GAP;
        end
      end
`endif
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register plus the registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= finish_s;
      // Stays high through the note_done cycle, drops on the one after.
      busy_r  <= (state_r != S_IDLE) || pend_valid_r || hs_s;
    end
  end

  // One-deep pending slot; fill and drain are mutually exclusive because
  // a fill needs the slot empty and a drain needs it full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_r <= 1'b0;
      pend_index_r <= '0;
      pend_dur_r   <= '0;
    end else if (hs_s) begin
      pend_valid_r <= 1'b1;
      pend_index_r <= note_index;
      pend_dur_r   <= note_duration;
    end else if (load_s) begin
      pend_valid_r <= 1'b0;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end

  // Current note, ms timer and tone generator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_rest_r <= 1'b0;
      cur_half_r <= 32'd0;
      tone_cnt_r <= 32'd0;
      ms_cnt_r   <= 32'd0;
      ms_left_r  <= 32'd0;
      audio_r    <= 1'b0;
    end else if (load_s) begin
      // Every note starts with the ms timer and tone phase restarted.
      cur_rest_r <= is_rest(pend_index_r);
      cur_half_r <= half_period(32'(pend_index_r));
      ms_left_r  <= 32'(pend_dur_r);
      ms_cnt_r   <= 32'd0;
      tone_cnt_r <= 32'd0;
      audio_r    <= 1'b0;
    end else if (state_next_s == S_IDLE) begin
      ms_left_r  <= 32'd0;
      ms_cnt_r   <= 32'd0;
      tone_cnt_r <= 32'd0;
      audio_r    <= 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
    end else if ((state_r == S_PLAY) && (state_next_s == S_GAP)) begin
      ms_left_r  <= 32'(GAP_MS);
      ms_cnt_r   <= 32'd0;
      tone_cnt_r <= 32'd0;
      audio_r    <= 1'b0;
`endif
    end else begin
      if (ms_cnt_r == (TICK - 32'd1)) begin
        ms_cnt_r  <= 32'd0;
        ms_left_r <= ms_left_r - 32'd1;
      end else begin
        ms_cnt_r  <= ms_cnt_r + 32'd1;
      end
      if ((state_r == S_PLAY) && !cur_rest_r) begin
        // >= rather than == keeps a degenerate zero half-period from wrapping.
        if ((tone_cnt_r + 32'd1) >= cur_half_r) begin
          tone_cnt_r <= 32'd0;
          audio_r    <= !audio_r;
        end else begin
          tone_cnt_r <= tone_cnt_r + 32'd1;
        end
      end else begin
        tone_cnt_r <= 32'd0;
        audio_r    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Directed testbench for note_player at CLOCK_HZ = 1 MHz (1000 cycles per ms).
// Times are counted in observation cycles k, sampled 1 time unit after each
// rising edge. All expectations are hand-derived from the note table.

module tb_note_player;

`ifdef NOTE_PLAYER_GAP_EN
  localparam int G = 2000;
`else
  localparam int G = 0;
`endif

  logic        clock;
  logic        reset_n;
  logic        note_valid;
  logic        note_ready;
  logic [5:0]  note_index;
  logic [15:0] note_duration;
  logic        audio_output;
  logic        busy;
  logic        note_done;

  int   vectors;
  int   miscompares;
  int   k;
  int   hs_k;
  logic prev_audio;
  int   chg_q[$];
  int   done_q[$];

  note_player #(
    .CLOCK_HZ(1000000),
    .NOTE_COUNT(36),
    .INDEX_WIDTH(6),
    .DURATION_WIDTH(16),
    .GAP_MS(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .note_valid(note_valid),
    .note_ready(note_ready),
    .note_index(note_index),
    .note_duration(note_duration),
    .audio_output(audio_output),
    .busy(busy),
    .note_done(note_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // One clock: record audio transitions and note_done pulses with their k.
  task automatic tick();
    @(posedge clock);
    #1;
    k++;
    if (audio_output !== prev_audio) chg_q.push_back(k);
    prev_audio = audio_output;
    if (note_done === 1'b1) done_q.push_back(k);
  endtask

  task automatic clear();
    k = 0;
    chg_q.delete();
    done_q.delete();
    prev_audio = audio_output;
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  // Hold a request until it is accepted (bounded); hs_k = handshake edge.
  task automatic send(input string tag, input logic [5:0] idx, input logic [15:0] dur);
    logic sent;
    sent = 1'b0;
    note_index    = idx;
    note_duration = dur;
    note_valid    = 1'b1;
    for (int i = 0; i < 20000 && !sent; i++) begin
      if (note_ready === 1'b1) sent = 1'b1;
      tick();
    end
    note_valid = 1'b0;
    hs_k = k;
    check({tag, "_accepted"}, 32'(sent), 32'd1);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    k             = 0;
    hs_k          = 0;
    prev_audio    = 1'b0;
    reset_n       = 1'b0;
    note_valid    = 1'b0;
    note_index    = 6'd0;
    note_duration = 16'd0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_audio", 32'(audio_output), 32'd0);
    check("rst_ready", 32'(note_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(note_done), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // A4 for 2 ms: rise after 1136 cycles of play, fall at 2000
    clear();
    send("t1", 6'd9, 16'd2);
    check("t1_hs_k", 32'(hs_k), 32'd1);
    check("t1_ready_after_hs", 32'(note_ready), 32'd0);
    check("t1_busy_after_hs",  32'(busy), 32'd1);
    tick();
    check("t1_ready_recovered", 32'(note_ready), 32'd1);
    run_to(2100 + G);
    check("t1_nchg",  32'(chg_q.size()), 32'd2);
    check("t1_rise",  32'(qget(chg_q, 0)), 32'd1138);
    check("t1_fall",  32'(qget(chg_q, 1)), 32'd2002);
    check("t1_ndone", 32'(done_q.size()), 32'd1);
    check("t1_done",  32'(qget(done_q, 0)), 32'(2002 + G));
    check("t1_busy_end", 32'(busy), 32'd0);

    // C4 then C5, 1 ms each: C4 (1908) never toggles within 1000 cycles,
    // C5 (956) starts on the edge C4 ends
    clear();
    send("t2a", 6'd0, 16'd1);
    send("t2b", 6'd12, 16'd1);
    check("t2_hs_k", 32'(hs_k), 32'd3);
    run_to(2100 + 2 * G);
    check("t2_nchg",  32'(chg_q.size()), 32'd2);
    check("t2_rise",  32'(qget(chg_q, 0)), 32'(1958 + G));
    check("t2_fall",  32'(qget(chg_q, 1)), 32'(2002 + G));
    check("t2_ndone", 32'(done_q.size()), 32'd2);
    check("t2_done0", 32'(qget(done_q, 0)), 32'(1002 + G));
    check("t2_done1", 32'(qget(done_q, 1)), 32'(2002 + 2 * G));

    // Rest index 63 for 3 ms
    clear();
    send("t3", 6'd63, 16'd3);
    run_to(1500);
    check("t3_busy_mid",  32'(busy), 32'd1);
    check("t3_audio_mid", 32'(audio_output), 32'd0);
    run_to(3100 + G);
    check("t3_nchg",  32'(chg_q.size()), 32'd0);
    check("t3_ndone", 32'(done_q.size()), 32'd1);
    check("t3_done",  32'(qget(done_q, 0)), 32'(3002 + G));
    check("t3_busy_end", 32'(busy), 32'd0);

    // Three requests back to back: third waits for the first note_done
    clear();
    send("t4a", 6'd9, 16'd1);
    send("t4b", 6'd12, 16'd1);
    send("t4c", 6'd21, 16'd1);
    check("t4_third_hs_k", 32'(hs_k), 32'(1003 + G));
    run_to(3100 + 3 * G);
    check("t4_nchg", 32'(chg_q.size()), 32'd4);
    check("t4_chg0", 32'(qget(chg_q, 0)), 32'(1958 + G));
    check("t4_chg1", 32'(qget(chg_q, 1)), 32'(2002 + G));
    check("t4_chg2", 32'(qget(chg_q, 2)), 32'(2570 + 2 * G));
    check("t4_chg3", 32'(qget(chg_q, 3)), 32'(3002 + 2 * G));
    check("t4_ndone", 32'(done_q.size()), 32'd3);
    check("t4_done0", 32'(qget(done_q, 0)), 32'(1002 + G));
    check("t4_done1", 32'(qget(done_q, 1)), 32'(2002 + 2 * G));
    check("t4_done2", 32'(qget(done_q, 2)), 32'(3002 + 3 * G));

    // Zero duration, out-of-range index 40
    clear();
    send("t5a", 6'd40, 16'd0);
    run_to(20 + G);
    check("t5a_nchg",  32'(chg_q.size()), 32'd0);
    check("t5a_ndone", 32'(done_q.size()), 32'd1);
    check("t5a_done",  32'(qget(done_q, 0)), 32'(3 + G));

    // Zero duration on a real note: still no tone
    clear();
    send("t5b", 6'd9, 16'd0);
    run_to(20 + G);
    check("t5b_nchg",  32'(chg_q.size()), 32'd0);
    check("t5b_ndone", 32'(done_q.size()), 32'd1);
    check("t5b_done",  32'(qget(done_q, 0)), 32'(3 + G));

    // Reset mid-note with a request pending
    clear();
    send("t6a", 6'd9, 16'd5);
    send("t6b", 6'd12, 16'd1);
    run_to(1200);
    check("t6_pre_audio", 32'(audio_output), 32'd1);
    check("t6_pre_ready", 32'(note_ready), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_audio", 32'(audio_output), 32'd0);
    check("t6_rst_busy",  32'(busy), 32'd0);
    check("t6_rst_ready", 32'(note_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    clear();
    run_to(3000);
    check("t6_post_nchg",  32'(chg_q.size()), 32'd0);
    check("t6_post_ndone", 32'(done_q.size()), 32'd0);
    check("t6_post_busy",  32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
